// File: rtl/control_sequencer.sv
// Hardwired control unit: walks fetch T0..T2 and per-opcode execute steps T3..T6,
// decoding datapath strobes as a Moore function of state and IR.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        memRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal,
    output logic [3:0]  tstep
);

    typedef enum logic [3:0] {
        T0     = 4'd0,
        T1     = 4'd1,
        T2     = 4'd2,
        T3     = 4'd3,
        T4     = 4'd4,
        T5     = 4'd5,
        T6     = 4'd6,
        HALTED = 4'd15
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t      r_state, w_next, w_boundary;
    logic [4:0]  w_op;
    logic [3:0]  w_ra, w_rb, w_rc;
    logic        w_alu3, w_unary, w_muldiv;
    logic        w_unused_ir;

    logic        w_pcout, w_incpc, w_marin, w_memread, w_mdrin, w_mdrout, w_irin;
    logic        w_yin, w_zin, w_zhighout, w_zlowout, w_hiin, w_loin, w_illegal;
    logic [15:0] w_rin, w_rout;
    logic [4:0]  w_alu_op;

    assign w_op        = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ^ir[14:0];

    assign w_alu3   = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                      (w_op == OP_AND) || (w_op == OP_OR);
    assign w_unary  = (w_op == OP_NEG) || (w_op == OP_NOT);
    assign w_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);

    // stop is only looked at in the final step of an instruction
    assign w_boundary = stop ? HALTED : T0;

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= T0;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pcout    = 1'b0;
        w_incpc    = 1'b0;
        w_marin    = 1'b0;
        w_memread  = 1'b0;
        w_mdrin    = 1'b0;
        w_mdrout   = 1'b0;
        w_irin     = 1'b0;
        w_yin      = 1'b0;
        w_zin      = 1'b0;
        w_zhighout = 1'b0;
        w_zlowout  = 1'b0;
        w_hiin     = 1'b0;
        w_loin     = 1'b0;
        w_illegal  = 1'b0;
        w_rin      = '0;
        w_rout     = '0;
        w_alu_op   = '0;
        case (r_state)
            T0: begin
                w_pcout = 1'b1;
                w_marin = 1'b1;
                w_incpc = 1'b1;
                w_next  = T1;
            end
            T1: begin
                w_memread = 1'b1;
                w_mdrin   = 1'b1;
                w_next    = T2;
            end
            T2: begin
                w_mdrout = 1'b1;
                w_irin   = 1'b1;
                if (w_alu3 || w_unary || w_muldiv) begin
                    w_next = T3;
                end else if (w_op == OP_HALT) begin
                    w_next = HALTED;
                end else if (w_op == OP_NOP) begin
                    w_next = w_boundary;
                end else begin
                    w_illegal = 1'b1;
                    w_next    = w_boundary;
                end
            end
            T3: begin
                w_alu_op = w_op;
                w_next   = T4;
                if (w_alu3) begin
                    w_rout = onehot(w_rb);
                    w_yin  = 1'b1;
                end else if (w_unary) begin
                    w_rout = onehot(w_rb);
                    w_zin  = 1'b1;
                end else if (w_muldiv) begin
                    w_rout = onehot(w_ra);
                    w_yin  = 1'b1;
                end else begin
                    w_next = w_boundary;
                end
            end
            T4: begin
                w_alu_op = w_op;
                if (w_alu3) begin
                    w_rout = onehot(w_rc);
                    w_zin  = 1'b1;
                    w_next = T5;
                end else if (w_unary) begin
                    w_zlowout = 1'b1;
                    w_rin     = onehot(w_ra);
                    w_next    = w_boundary;
                end else if (w_muldiv) begin
                    w_rout = onehot(w_rb);
                    w_zin  = 1'b1;
                    w_next = T5;
                end else begin
                    w_next = w_boundary;
                end
            end
            T5: begin
                w_alu_op = w_op;
                w_next   = w_boundary;
                if (w_alu3) begin
                    w_zlowout = 1'b1;
                    w_rin     = onehot(w_ra);
                end else if (w_muldiv) begin
                    w_zlowout = 1'b1;
                    w_loin    = 1'b1;
                    w_next    = T6;
                end
            end
            T6: begin
                w_alu_op = w_op;
                w_next   = w_boundary;
                if (w_muldiv) begin
                    w_zhighout = 1'b1;
                    w_hiin     = 1'b1;
                end
            end
            HALTED: begin
                // stop beats start so a held halt request keeps the machine parked
                if (start && !stop) w_next = T0;
            end
            default: w_next = T0;
        endcase
    end

    // clear masks the decode so no strobe escapes while reset is held
    assign PCout    = clear & w_pcout;
    assign IncPC    = clear & w_incpc;
    assign MARin    = clear & w_marin;
    assign memRead  = clear & w_memread;
    assign MDRin    = clear & w_mdrin;
    assign MDRout   = clear & w_mdrout;
    assign IRin     = clear & w_irin;
    assign Yin      = clear & w_yin;
    assign Zin      = clear & w_zin;
    assign Zhighout = clear & w_zhighout;
    assign Zlowout  = clear & w_zlowout;
    assign HIin     = clear & w_hiin;
    assign LOin     = clear & w_loin;
    assign illegal  = clear & w_illegal;
    assign Rin      = clear ? w_rin    : '0;
    assign Rout     = clear ? w_rout   : '0;
    assign alu_op   = clear ? w_alu_op : '0;
    assign run      = (r_state != HALTED);
    assign tstep    = r_state;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 clear  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  leave HALTED and resume fetch; level-sampled.
REQ-004 stop  input  1  halt request, honoured at next instruction boundary.
REQ-005 ir  input  32  datapath IR contents; opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
REQ-006 PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin  output  1 each  fetch-path strobes to datapath.
REQ-007 Yin, Zin, Zhighout, Zlowout, HIin, LOin  output  1 each  ALU-path strobes to datapath.
REQ-008 Rin  output  16  one-hot register write enable; bit n selects Rn.
REQ-009 Rout  output  16  one-hot register bus drive; bit n selects Rn.
REQ-010 alu_op  output  5  ALU operation; equals ir[31:27] in execute states, 0 otherwise.
REQ-011 run  output  1  high in every state except HALTED.
REQ-012 illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-013 tstep  output  4  current state encoding, debug only.

Function
REQ-014 States, one clock each: T0=0, T1=1, T2=2, T3=3, T4=4, T5=5, T6=6, HALTED=15.
REQ-015 All strobes, Rin, Rout, alu_op are Moore decodes of state and ir only; every signal not listed for a state is 0.
REQ-016 T0: PCout, MARin, IncPC =1; next T1.
REQ-017 T1: memRead, MDRin =1; next T2.
REQ-018 T2: MDRout, IRin =1; next T3, except NOP (11010) -> boundary, HALT (11011) -> HALTED, unsupported -> boundary with illegal=1 in T2.
REQ-019 ir is sampled only in T3..T6 and in T2 for opcode routing after IR latch; bench holds ir stable from end of T2.
REQ-020 ADD 00011, SUB 00100, AND 00101, OR 00110: T3 Rout[rb], Yin; T4 Rout[rc], Zin; T5 Zlowout, Rin[ra]; then boundary.
REQ-021 NEG 10001, NOT 10010: T3 Rout[rb], Zin; T4 Zlowout, Rin[ra]; then boundary.
REQ-022 MUL 10000, DIV 01111: T3 Rout[ra], Yin; T4 Rout[rb], Zin; T5 Zlowout, LOin; T6 Zhighout, HIin; then boundary.
REQ-023 Boundary: next state T0 if stop=0, HALTED if stop=1 in the last cycle of the instruction.
REQ-024 stop asserted mid-instruction does not abort; instruction completes all steps.
REQ-025 HALTED: all strobes 0, run=0; start=1 -> T0 next cycle; start and stop both 1 -> stop wins, remain HALTED.
REQ-026 Rin/Rout never have more than one bit set; at most one bus driver (PCout, MDRout, Zlowout, Zhighout, Rout) active per state.
REQ-027 Register index 0..15 decodes to Rout/Rin bit of same index; no special R0 handling.

Reset
REQ-028 clear=0 forces state T0 immediately, run=1, illegal=0, all strobes/Rin/Rout/alu_op 0 while clear=0 regardless of clock.
REQ-029 First rising edge after clear returns to 1 enters T1 (T0 presented for one full cycle).
REQ-030 clear mid-instruction discards in-progress instruction; no partial Rin/HIin/LOin pulse after assertion.

Verification
REQ-031 NOT R6,R7: ir=0x9338_0000 -> T3 Rout=0x0080, Zin=1, alu_op=0x12; T4 Zlowout=1, Rin=0x0040; next T0.
REQ-032 ADD R2,R5,R6: ir=0x192B_0000 -> T3 Rout=0x0020, Yin; T4 Rout=0x0040, Zin, alu_op=0x03; T5 Rin=0x0004, Zlowout.
REQ-033 MUL R3,R1: ir=0x8188_0000 -> T3 Rout=0x0008, Yin; T4 Rout=0x0002, Zin; T5 LOin, Zlowout; T6 HIin, Zhighout; 7 cycles total.
REQ-034 HALT: ir=0xD800_0000 -> after T2 state 15, run=0, strobes 0; start=1 one cycle -> T0, PCout=MARin=IncPC=1.
REQ-035 stop=1 raised in T3 of NOT -> T4 completes with Rin=0x0040, then HALTED; illegal opcode 0x1F -> illegal=1 in T2, next T0.
REQ-036 clear=0 asserted in T4 of ADD -> immediate T0 decode with strobes 0, no Rin pulse; after release T0 then T1.
